// File: rtl/bcd_score_converter.sv
// Serial double-dabble binary-to-BCD converter for score/level display.
// One shift per clock under a start/busy/done handshake, plus a digit mux with leading-zero blanking.
module bcd_score_converter #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  input  logic [SEL_W-1:0]      digit_sel,
  output logic [3:0]            display_num,
  output logic                  blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT        = pow10(DIGITS);
  // When every BIN_W-bit value fits in DIGITS digits the flag is tied low.
  localparam bit          OVF_POSSIBLE = (64'd1 << BIN_W) > LIMIT;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d, scratch_adj;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              ovf_calc;

  assign ovf_calc = OVF_POSSIBLE && (64'(bin_in) >= LIMIT);

  // Add-3 correction on every scratch digit before each shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                  ? scratch_q[4*gi +: 4] + 4'd3
                                  : scratch_q[4*gi +: 4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (count_q == CNT_W'(BIN_W - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT) || (state_q == S_DONE);
  end

  always_comb begin
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d    = bin_in;
          scratch_d  = '0;
          count_d    = '0;
          ovf_pend_d = ovf_calc;
        end
      end
      S_SHIFT: begin
        // The top bit of the most significant digit falls off here.
        scratch_d = {scratch_adj[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_d   = shift_q << 1;
        count_d   = count_q + CNT_W'(1);
      end
      S_DONE: begin
        bcd_d      = ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;
  assign done     = done_q;

  // Walk from the top digit down so zeros_above covers the selected digit and everything above it.
  always_comb begin
    logic zeros_above;
    zeros_above = 1'b1;
    display_num = 4'h0;
    blank       = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zeros_above = zeros_above && (bcd_q[4*k +: 4] == 4'h0);
      if (int'(digit_sel) == k) begin
        display_num = bcd_q[4*k +: 4];
        blank       = (k != 0) && zeros_above && !overflow_q;
      end
    end
  end

endmodule

// File: tb/tb_bcd_score_converter.sv
// Self-checking bench for bcd_score_converter: three configurations (8/3, 8/2, 16/5)
// with a per-DUT scoreboard filled at start and drained on each done pulse.
module tb_bcd_score_converter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, a_busy, a_done, a_ovf, a_blank;
  logic [7:0]  a_bin = '0;
  logic [11:0] a_bcd;
  logic [1:0]  a_sel = '0;
  logic [3:0]  a_num;

  logic        b_start = 1'b0, b_busy, b_done, b_ovf, b_blank;
  logic [7:0]  b_bin = '0;
  logic [7:0]  b_bcd;
  logic [0:0]  b_sel = '0;
  logic [3:0]  b_num;

  logic        c_start = 1'b0, c_busy, c_done, c_ovf, c_blank;
  logic [15:0] c_bin = '0;
  logic [19:0] c_bcd;
  logic [2:0]  c_sel = '0;
  logic [3:0]  c_num;

  bcd_score_converter #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .bin_in(a_bin), .busy(a_busy),
    .done(a_done), .bcd_out(a_bcd), .overflow(a_ovf), .digit_sel(a_sel),
    .display_num(a_num), .blank(a_blank));

  bcd_score_converter #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .bin_in(b_bin), .busy(b_busy),
    .done(b_done), .bcd_out(b_bcd), .overflow(b_ovf), .digit_sel(b_sel),
    .display_num(b_num), .blank(b_blank));

  bcd_score_converter #(.BIN_W(16), .DIGITS(5)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(c_start), .bin_in(c_bin), .busy(c_busy),
    .done(c_done), .bcd_out(c_bcd), .overflow(c_ovf), .digit_sel(c_sel),
    .display_num(c_num), .blank(c_blank));

  int tests_run = 0;
  int tests_failed = 0;

  logic [40:0] qa[$], qb[$], qc[$];
  logic [40:0] a_exp, b_exp, c_exp;
  int a_dones = 0, b_dones = 0, c_dones = 0;

  // Reference: {overflow, bcd digits}, saturating to all nines on overflow.
  function automatic logic [40:0] model(input longint unsigned v, input int d);
    longint unsigned lim, x;
    logic [39:0] r;
    lim = 1;
    x = v;
    r = '0;
    for (int i = 0; i < d; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
      return {1'b1, r};
    end
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      a_dones++;
      tests_run++;
      if (qa.size() == 0) begin
        tests_failed++;
        $display("FAIL a_sb_unexpected_done: got bcd=%h, required no done pulse", a_bcd);
      end else begin
        a_exp = qa.pop_front();
        if ({a_ovf, a_bcd} !== {a_exp[40], a_exp[11:0]}) begin
          tests_failed++;
          $display("FAIL a_sb_result: got ovf=%b bcd=%h, required ovf=%b bcd=%h",
                   a_ovf, a_bcd, a_exp[40], a_exp[11:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_done === 1'b1) begin
      b_dones++;
      tests_run++;
      if (qb.size() == 0) begin
        tests_failed++;
        $display("FAIL b_sb_unexpected_done: got bcd=%h, required no done pulse", b_bcd);
      end else begin
        b_exp = qb.pop_front();
        if ({b_ovf, b_bcd} !== {b_exp[40], b_exp[7:0]}) begin
          tests_failed++;
          $display("FAIL b_sb_result: got ovf=%b bcd=%h, required ovf=%b bcd=%h",
                   b_ovf, b_bcd, b_exp[40], b_exp[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (c_done === 1'b1) begin
      c_dones++;
      tests_run++;
      if (qc.size() == 0) begin
        tests_failed++;
        $display("FAIL c_sb_unexpected_done: got bcd=%h, required no done pulse", c_bcd);
      end else begin
        c_exp = qc.pop_front();
        if ({c_ovf, c_bcd} !== {c_exp[40], c_exp[19:0]}) begin
          tests_failed++;
          $display("FAIL c_sb_result: got ovf=%b bcd=%h, required ovf=%b bcd=%h",
                   c_ovf, c_bcd, c_exp[40], c_exp[19:0]);
        end
      end
    end
  end

  // Each run helper returns at the negedge where done is seen (edges = -1 on timeout).
  task automatic a_run(input logic [7:0] v, input bit immediate, output int edges, output int busy_cycles);
    qa.push_back(model(v, 3));
    if (!immediate) @(negedge clk);
    a_start = 1'b1; a_bin = v;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0; a_bin = 8'($urandom);
    edges = -1; busy_cycles = 0;
    if (a_busy) busy_cycles++;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); @(negedge clk);
      if (a_done) begin edges = e; break; end
      if (a_busy) busy_cycles++;
    end
  endtask

  task automatic b_run(input logic [7:0] v, output int edges);
    qb.push_back(model(v, 2));
    @(negedge clk);
    b_start = 1'b1; b_bin = v;
    @(posedge clk);
    @(negedge clk);
    b_start = 1'b0; b_bin = 8'($urandom);
    edges = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); @(negedge clk);
      if (b_done) begin edges = e; break; end
    end
  endtask

  task automatic c_run(input logic [15:0] v, output int edges);
    qc.push_back(model(v, 5));
    @(negedge clk);
    c_start = 1'b1; c_bin = v;
    @(posedge clk);
    @(negedge clk);
    c_start = 1'b0; c_bin = 16'($urandom);
    edges = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); @(negedge clk);
      if (c_done) begin edges = e; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({a_busy, a_done, a_ovf, a_bcd} !== 15'h0) begin
      tests_failed++;
      $display("FAIL reset_a: got busy=%b done=%b ovf=%b bcd=%h, required all 0", a_busy, a_done, a_ovf, a_bcd);
    end
    tests_run++;
    if ({b_busy, b_done, b_ovf, b_bcd, c_busy, c_done, c_ovf, c_bcd} !== 34'h0) begin
      tests_failed++;
      $display("FAIL reset_bc: got b_bcd=%h c_bcd=%h b_busy=%b c_busy=%b, required all 0", b_bcd, c_bcd, b_busy, c_busy);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max();
    int edges, busy_cycles;
    logic [3:0] exp_d [3];
    exp_d[0] = 4'd5; exp_d[1] = 4'd5; exp_d[2] = 4'd2;
    a_run(8'd255, 1'b0, edges, busy_cycles);
    $display("[TB] a: 255 -> done after %0d edges, busy %0d cycles, bcd=%h", edges, busy_cycles, a_bcd);
    tests_run++;
    if (edges !== 9) begin tests_failed++; $display("FAIL max_done_latency: got %0d edges, required 9", edges); end
    tests_run++;
    if (busy_cycles !== 9) begin tests_failed++; $display("FAIL max_busy_cycles: got %0d, required 9", busy_cycles); end
    tests_run++;
    if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL max_busy_in_done: got %b, required 0", a_busy); end
    for (int s = 0; s < 3; s++) begin
      a_sel = 2'(s);
      #1;
      tests_run++;
      if (a_num !== exp_d[s] || a_blank !== 1'b0) begin
        tests_failed++;
        $display("FAIL max_digit%0d: got num=%0d blank=%b, required num=%0d blank=0", s, a_num, a_blank, exp_d[s]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (a_done !== 1'b0) begin tests_failed++; $display("FAIL max_done_width: got done=%b one cycle later, required 0", a_done); end
  endtask

  task automatic test_blanking();
    int edges, busy_cycles;
    a_run(8'd0, 1'b0, edges, busy_cycles);
    $display("[TB] a: 0 -> bcd=%h", a_bcd);
    a_sel = 2'd0; #1;
    tests_run++;
    if (a_num !== 4'd0 || a_blank !== 1'b0) begin tests_failed++; $display("FAIL zero_digit0: got num=%0d blank=%b, required num=0 blank=0", a_num, a_blank); end
    for (int s = 1; s < 3; s++) begin
      a_sel = 2'(s); #1;
      tests_run++;
      if (a_blank !== 1'b1) begin tests_failed++; $display("FAIL zero_blank%0d: got blank=%b, required 1", s, a_blank); end
    end
    a_run(8'd7, 1'b0, edges, busy_cycles);
    $display("[TB] a: 7 -> bcd=%h", a_bcd);
    a_sel = 2'd0; #1;
    tests_run++;
    if (a_num !== 4'd7 || a_blank !== 1'b0) begin tests_failed++; $display("FAIL seven_digit0: got num=%0d blank=%b, required num=7 blank=0", a_num, a_blank); end
    for (int s = 1; s < 3; s++) begin
      a_sel = 2'(s); #1;
      tests_run++;
      if (a_blank !== 1'b1) begin tests_failed++; $display("FAIL seven_blank%0d: got blank=%b, required 1", s, a_blank); end
    end
    a_sel = 2'd3; #1;
    tests_run++;
    if (a_num !== 4'd0 || a_blank !== 1'b1) begin tests_failed++; $display("FAIL sel_out_of_range: got num=%0d blank=%b, required num=0 blank=1", a_num, a_blank); end
    a_run(8'd105, 1'b0, edges, busy_cycles);
    $display("[TB] a: 105 -> bcd=%h", a_bcd);
    a_sel = 2'd1; #1;
    tests_run++;
    if (a_num !== 4'd0 || a_blank !== 1'b0) begin tests_failed++; $display("FAIL inner_zero: got num=%0d blank=%b, required num=0 blank=0", a_num, a_blank); end
  endtask

  task automatic test_overflow();
    int edges;
    b_run(8'd100, edges);
    $display("[TB] b: 100 -> done after %0d edges, ovf=%b bcd=%h", edges, b_ovf, b_bcd);
    tests_run++;
    if (edges !== 9) begin tests_failed++; $display("FAIL ovf_latency: got %0d edges, required 9", edges); end
    for (int s = 0; s < 2; s++) begin
      b_sel = 1'(s); #1;
      tests_run++;
      if (b_num !== 4'd9 || b_blank !== 1'b0) begin tests_failed++; $display("FAIL ovf_digit%0d: got num=%0d blank=%b, required num=9 blank=0", s, b_num, b_blank); end
    end
    b_run(8'd42, edges);
    $display("[TB] b: 42 -> ovf=%b bcd=%h", b_ovf, b_bcd);
    b_sel = 1'd1; #1;
    tests_run++;
    if (b_num !== 4'd4 || b_blank !== 1'b0) begin tests_failed++; $display("FAIL b42_digit1: got num=%0d blank=%b, required num=4 blank=0", b_num, b_blank); end
    b_run(8'd5, edges);
    $display("[TB] b: 5 -> ovf=%b bcd=%h", b_ovf, b_bcd);
    #1;
    tests_run++;
    if (b_blank !== 1'b1) begin tests_failed++; $display("FAIL b5_blank1: got blank=%b, required 1", b_blank); end
  endtask

  task automatic test_start_held();
    int edges, d0;
    edges = -1;
    d0 = a_dones;
    qa.push_back(model(8'd123, 3));
    @(negedge clk);
    a_start = 1'b1; a_bin = 8'd123;
    @(posedge clk);
    @(negedge clk);
    for (int e = 1; e <= 30; e++) begin
      if (e <= 6) a_bin = 8'($urandom);
      if (e == 6) a_start = 1'b0;
      @(posedge clk); @(negedge clk);
      if (a_done && edges < 0) edges = e;
    end
    $display("[TB] a: 123 with start held -> done after %0d edges, %0d done pulses", edges, a_dones - d0);
    tests_run++;
    if (edges !== 9) begin tests_failed++; $display("FAIL held_latency: got %0d edges, required 9", edges); end
    tests_run++;
    if (a_dones - d0 !== 1) begin tests_failed++; $display("FAIL held_done_count: got %0d, required 1", a_dones - d0); end
  endtask

  task automatic test_back_to_back();
    int edges, busy_cycles;
    a_run(8'd77, 1'b0, edges, busy_cycles);
    a_run(8'd201, 1'b1, edges, busy_cycles);
    $display("[TB] a: back-to-back 77,201 -> second done after %0d edges, bcd=%h", edges, a_bcd);
    tests_run++;
    if (edges !== 9) begin tests_failed++; $display("FAIL b2b_latency: got %0d edges, required 9", edges); end
  endtask

  task automatic test_reset_abort();
    int edges, busy_cycles, d0;
    @(negedge clk);
    a_start = 1'b1; a_bin = 8'd200;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    $display("[TB] a: reset 4 edges into 200 -> busy=%b done=%b bcd=%h", a_busy, a_done, a_bcd);
    tests_run++;
    if ({a_busy, a_done, a_ovf, a_bcd} !== 15'h0) begin
      tests_failed++;
      $display("FAIL abort_async: got busy=%b done=%b ovf=%b bcd=%h, required all 0", a_busy, a_done, a_ovf, a_bcd);
    end
    d0 = a_dones;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    tests_run++;
    if (a_dones !== d0) begin tests_failed++; $display("FAIL abort_no_done: got %0d done pulses, required 0", a_dones - d0); end
    a_run(8'd200, 1'b0, edges, busy_cycles);
    $display("[TB] a: 200 after reset -> done after %0d edges, bcd=%h", edges, a_bcd);
    tests_run++;
    if (edges !== 9) begin tests_failed++; $display("FAIL abort_restart_latency: got %0d edges, required 9", edges); end
  endtask

  task automatic test_wide();
    int edges;
    c_run(16'd65535, edges);
    $display("[TB] c: 65535 -> done after %0d edges, ovf=%b bcd=%h", edges, c_ovf, c_bcd);
    tests_run++;
    if (edges !== 17) begin tests_failed++; $display("FAIL wide_latency: got %0d edges, required 17", edges); end
    c_sel = 3'd4; #1;
    tests_run++;
    if (c_num !== 4'd6 || c_blank !== 1'b0) begin tests_failed++; $display("FAIL wide_digit4: got num=%0d blank=%b, required num=6 blank=0", c_num, c_blank); end
    c_sel = 3'd5; #1;
    tests_run++;
    if (c_num !== 4'd0 || c_blank !== 1'b1) begin tests_failed++; $display("FAIL wide_sel5: got num=%0d blank=%b, required num=0 blank=1", c_num, c_blank); end
    c_run(16'd9041, edges);
    $display("[TB] c: 9041 -> bcd=%h", c_bcd);
    c_sel = 3'd3; #1;
    tests_run++;
    if (c_num !== 4'd9 || c_blank !== 1'b0) begin tests_failed++; $display("FAIL wide_9041_d3: got num=%0d blank=%b, required num=9 blank=0", c_num, c_blank); end
  endtask

  task automatic test_drain();
    repeat (3) @(negedge clk);
    tests_run++;
    if (qa.size() + qb.size() + qc.size() !== 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d results outstanding, required 0", qa.size() + qb.size() + qc.size());
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_blanking();
    test_overflow();
    test_start_held();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
